cl_axil_buf_bank: RTL and testbench

//  AXI-Lite (OCL BAR0) slave giving host access to NUM_BUF on-chip word buffers, each DEPTH x 32b.

---
 rtl/cl_axil_buf_bank_if.sv | 36 +++
 rtl/cl_axil_buf_bank.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cl_axil_buf_bank.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cl_axil_buf_bank_if.sv
// AXI-Lite slave bus bundle for the OCL buffer bank.
// Handshakes: a beat transfers on a rising edge where valid && ready; once valid is raised its payload
// stays stable and valid stays high until that edge; ready may be driven independently of valid.
interface cl_axil_buf_bank_if;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid;
  logic [1:0]  s_bresp;
  logic        s_bready;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rready;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output s_arready, s_rvalid, s_rdata, s_rresp
  );
endinterface

// File: rtl/cl_axil_buf_bank.sv
// AXI-Lite register slave exposing NUM_BUF word buffers with auto-increment DATA ports,
// pointer/dimension/status registers, and a read-only core port into the same storage.
module cl_axil_buf_bank #(
  parameter int NUM_BUF    = 2,
  parameter int DEPTH      = 256,
  parameter int BUF_STRIDE = 'h20,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int BUF_W     = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
  input  logic                   clk_main_a0,
  input  logic                   rst_main_n,
  cl_axil_buf_bank_if.slave      axil,
  input  logic                   core_rd_en,
  input  logic [BUF_W-1:0]       core_rd_buf,
  input  logic [PTR_W-1:0]       core_rd_addr,
  output logic [31:0]            core_rd_data,
  output logic [8*NUM_BUF-1:0]   cfg_length,
  output logic [8*NUM_BUF-1:0]   cfg_width,
  output logic [1:0]             dbg_w_state,
  output logic [1:0]             dbg_r_state
);

  localparam int OFF_W  = $clog2(BUF_STRIDE);
  localparam int MEM_AW = BUF_W + PTR_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA, R_RESP} r_state_e;
  typedef enum logic [2:0] {REG_DATA, REG_WR_PTR, REG_RD_PTR, REG_DIM, REG_STATUS, REG_NONE} reg_e;

  function automatic reg_e decode_reg(input logic [31:0] addr);
    logic [31:0] idx;
    logic [31:0] off;
    idx = addr >> OFF_W;
    off = addr & 32'(BUF_STRIDE - 1) & ~32'h3;
    decode_reg = REG_NONE;
    if (idx < 32'(NUM_BUF)) begin
      case (off)
        32'h00:  decode_reg = REG_DATA;
        32'h04:  decode_reg = REG_WR_PTR;
        32'h08:  decode_reg = REG_RD_PTR;
        32'h0C:  decode_reg = REG_DIM;
        32'h10:  decode_reg = REG_STATUS;
        default: decode_reg = REG_NONE;
      endcase
    end
  endfunction

  function automatic logic [BUF_W-1:0] decode_buf(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> OFF_W;
    decode_buf = idx[BUF_W-1:0];
  endfunction

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic [31:0]       aw_addr_q, aw_addr_d;
  logic [31:0]       ar_addr_q, ar_addr_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [1:0]        rsp_pend_q, rsp_pend_d;
  logic [31:0]       reg_rd_q, reg_rd_d;
  logic              rd_is_ram_q, rd_is_ram_d;
  logic [PTR_W-1:0]  wr_ptr_q [NUM_BUF];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_BUF];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_BUF];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_BUF];
  logic [15:0]       dim_q [NUM_BUF];
  logic [15:0]       dim_d [NUM_BUF];
  logic [NUM_BUF-1:0] wr_wrap_q, wr_wrap_d, wr_wrap_set;
  logic [NUM_BUF-1:0] rd_wrap_q, rd_wrap_d, rd_wrap_set;
  logic [31:0]       core_rd_data_q;
  logic [31:0]       ram_rd_q;

  reg_e              w_reg, r_reg;
  logic [BUF_W-1:0]  w_buf, r_buf;
  logic              w_commit, data_wr_commit;
  logic              mem_we, ram_re;
  logic [MEM_AW-1:0] mem_waddr, ram_raddr;
  logic [31:0]       reg_value;
  logic [PTR_W-1:0]  ptr_diff;

  logic [31:0] mem [NUM_BUF*DEPTH];

  assign w_reg          = decode_reg(aw_addr_q);
  assign w_buf          = decode_buf(aw_addr_q);
  assign r_reg          = decode_reg(ar_addr_q);
  assign r_buf          = decode_buf(ar_addr_q);
  assign w_commit       = (w_state_q == W_DATA) && axil.s_wvalid;
  assign data_wr_commit = w_commit && (w_reg == REG_DATA);
  assign mem_waddr      = {w_buf, wr_ptr_q[w_buf]};
  assign ram_raddr      = {r_buf, rd_ptr_q[r_buf]};
  assign ptr_diff       = wr_ptr_q[r_buf] - rd_ptr_q[r_buf];

  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: if (axil.s_awvalid) begin
        aw_addr_d = axil.s_awaddr;
        w_state_d = W_DATA;
      end
      W_DATA: if (axil.s_wvalid) begin
        bresp_d   = (w_reg == REG_NONE) ? 2'b10 : 2'b00;
        w_state_d = W_RESP;
      end
      W_RESP: if (axil.s_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    reg_value = 32'h0;
    case (r_reg)
      REG_WR_PTR: reg_value = 32'(wr_ptr_q[r_buf]);
      REG_RD_PTR: reg_value = 32'(rd_ptr_q[r_buf]);
      REG_DIM:    reg_value = {16'h0, dim_q[r_buf]};
      REG_STATUS: reg_value = {16'(ptr_diff), 14'h0, rd_wrap_q[r_buf], wr_wrap_q[r_buf]};
      default:    reg_value = 32'h0;
    endcase
  end

  // A DATA write committing in R_ISSUE holds the read off one cycle so RAM port use never collides.
  always_comb begin
    r_state_d   = r_state_q;
    ar_addr_d   = ar_addr_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rsp_pend_d  = rsp_pend_q;
    reg_rd_d    = reg_rd_q;
    rd_is_ram_d = rd_is_ram_q;
    ram_re      = 1'b0;
    case (r_state_q)
      R_IDLE: if (axil.s_arvalid) begin
        ar_addr_d = axil.s_araddr;
        r_state_d = R_ISSUE;
      end
      R_ISSUE: if (!data_wr_commit) begin
        rd_is_ram_d = (r_reg == REG_DATA);
        ram_re      = (r_reg == REG_DATA);
        rsp_pend_d  = (r_reg == REG_NONE) ? 2'b10 : 2'b00;
        reg_rd_d    = reg_value;
        r_state_d   = R_DATA;
      end
      R_DATA: begin
        rdata_d   = rd_is_ram_q ? ram_rd_q : reg_rd_q;
        rresp_d   = rsp_pend_q;
        r_state_d = R_RESP;
      end
      R_RESP: if (axil.s_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read-side increment first so an explicit RD_PTR load in the same cycle takes precedence.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    dim_d       = dim_q;
    wr_wrap_d   = wr_wrap_q;
    rd_wrap_d   = rd_wrap_q;
    wr_wrap_set = '0;
    rd_wrap_set = '0;
    mem_we      = 1'b0;
    if (ram_re) begin
      rd_ptr_d[r_buf] = rd_ptr_q[r_buf] + 1'b1;
      if (rd_ptr_q[r_buf] == PTR_W'(DEPTH - 1)) rd_wrap_set[r_buf] = 1'b1;
    end
    if (w_commit) begin
      case (w_reg)
        REG_DATA: begin
          mem_we          = 1'b1;
          wr_ptr_d[w_buf] = wr_ptr_q[w_buf] + 1'b1;
          if (wr_ptr_q[w_buf] == PTR_W'(DEPTH - 1)) wr_wrap_set[w_buf] = 1'b1;
        end
        REG_WR_PTR: if (axil.s_wstrb[0]) wr_ptr_d[w_buf] = axil.s_wdata[PTR_W-1:0];
        REG_RD_PTR: if (axil.s_wstrb[0]) rd_ptr_d[w_buf] = axil.s_wdata[PTR_W-1:0];
        REG_DIM: begin
          if (axil.s_wstrb[0]) dim_d[w_buf][7:0]  = axil.s_wdata[7:0];
          if (axil.s_wstrb[1]) dim_d[w_buf][15:8] = axil.s_wdata[15:8];
        end
        REG_STATUS: if (axil.s_wstrb[0]) begin
          if (axil.s_wdata[0]) wr_wrap_d[w_buf] = 1'b0;
          if (axil.s_wdata[1]) rd_wrap_d[w_buf] = 1'b0;
        end
        default: ;
      endcase
    end
    wr_wrap_d = wr_wrap_d | wr_wrap_set;
    rd_wrap_d = rd_wrap_d | rd_wrap_set;
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      bresp_q     <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rsp_pend_q  <= '0;
      reg_rd_q    <= '0;
      rd_is_ram_q <= 1'b0;
      wr_wrap_q   <= '0;
      rd_wrap_q   <= '0;
      for (int b = 0; b < NUM_BUF; b++) begin
        wr_ptr_q[b] <= '0;
        rd_ptr_q[b] <= '0;
        dim_q[b]    <= '0;
      end
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      aw_addr_q   <= aw_addr_d;
      ar_addr_q   <= ar_addr_d;
      bresp_q     <= bresp_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rsp_pend_q  <= rsp_pend_d;
      reg_rd_q    <= reg_rd_d;
      rd_is_ram_q <= rd_is_ram_d;
      wr_wrap_q   <= wr_wrap_d;
      rd_wrap_q   <= rd_wrap_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dim_q       <= dim_d;
    end
  end

  // Storage is not reset; reads of the old word on a same-cycle write fall out of read-first ordering.
  always_ff @(posedge clk_main_a0) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (axil.s_wstrb[i]) mem[mem_waddr][8*i +: 8] <= axil.s_wdata[8*i +: 8];
      end
    end
    if (ram_re) ram_rd_q <= mem[ram_raddr];
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) core_rd_data_q <= '0;
    else if (core_rd_en) core_rd_data_q <= mem[{core_rd_buf, core_rd_addr}];
  end

  assign axil.s_awready = (w_state_q == W_IDLE);
  assign axil.s_wready  = (w_state_q == W_DATA);
  assign axil.s_bvalid  = (w_state_q == W_RESP);
  assign axil.s_bresp   = bresp_q;
  assign axil.s_arready = (r_state_q == R_IDLE);
  assign axil.s_rvalid  = (r_state_q == R_RESP);
  assign axil.s_rdata   = rdata_q;
  assign axil.s_rresp   = rresp_q;
  assign core_rd_data   = core_rd_data_q;
  assign dbg_w_state    = w_state_q;
  assign dbg_r_state    = r_state_q;

  for (genvar b = 0; b < NUM_BUF; b++) begin : g_cfg
    assign cfg_length[8*b +: 8] = dim_q[b][7:0];
    assign cfg_width[8*b +: 8]  = dim_q[b][15:8];
  end

endmodule

// File: tb/tb_cl_axil_buf_bank.sv
// Bench for cl_axil_buf_bank: directed vector table, multi-cycle corner sequences, and
// randomized traffic checked against a word-array reference model of the register map.
module tb_cl_axil_buf_bank;
  localparam int NUM_BUF = 2;
  localparam int DEPTH   = 256;
  localparam int STRIDE  = 'h20;
  localparam int BOUND   = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cl_axil_buf_bank_if axil ();
  logic        core_rd_en;
  logic [0:0]  core_rd_buf;
  logic [7:0]  core_rd_addr;
  logic [31:0] core_rd_data;
  logic [15:0] cfg_length, cfg_width;
  logic [1:0]  dbg_w_state, dbg_r_state;

  cl_axil_buf_bank #(.NUM_BUF(NUM_BUF), .DEPTH(DEPTH), .BUF_STRIDE(STRIDE)) dut (
    .clk_main_a0 (clk),
    .rst_main_n  (rst_n),
    .axil        (axil.slave),
    .core_rd_en  (core_rd_en),
    .core_rd_buf (core_rd_buf),
    .core_rd_addr(core_rd_addr),
    .core_rd_data(core_rd_data),
    .cfg_length  (cfg_length),
    .cfg_width   (cfg_width),
    .dbg_w_state (dbg_w_state),
    .dbg_r_state (dbg_r_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expire(input string what);
    checks++;
    errors++;
    $display("FAIL timeout %s: no handshake within %0d cycles", what, BOUND);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem   [NUM_BUF][DEPTH];
  bit          m_known [NUM_BUF][DEPTH];
  int          m_wr [NUM_BUF];
  int          m_rd [NUM_BUF];
  logic [7:0]  m_len [NUM_BUF];
  logic [7:0]  m_wid [NUM_BUF];
  bit          m_wwrap [NUM_BUF];
  bit          m_rwrap [NUM_BUF];

  function automatic void m_reset();
    for (int b = 0; b < NUM_BUF; b++) begin
      m_wr[b] = 0; m_rd[b] = 0; m_len[b] = 0; m_wid[b] = 0;
      m_wwrap[b] = 0; m_rwrap[b] = 0;
    end
  endfunction

  function automatic void m_write(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [3:0] strb, output logic [1:0] resp);
    int b, off;
    resp = 2'b10;
    if ((addr / STRIDE) >= NUM_BUF) return;
    b   = int'(addr / STRIDE);
    off = int'(addr % STRIDE) & ~3;
    if (off > 'h10) return;
    resp = 2'b00;
    case (off)
      'h00: begin
        for (int i = 0; i < 4; i++) if (strb[i]) m_mem[b][m_wr[b]][8*i +: 8] = data[8*i +: 8];
        m_known[b][m_wr[b]] = m_known[b][m_wr[b]] || (strb == 4'hF);
        m_wr[b] = (m_wr[b] + 1) % DEPTH;
        if (m_wr[b] == 0) m_wwrap[b] = 1;
      end
      'h04: if (strb[0]) m_wr[b] = int'(data % DEPTH);
      'h08: if (strb[0]) m_rd[b] = int'(data % DEPTH);
      'h0C: begin
        if (strb[0]) m_len[b] = data[7:0];
        if (strb[1]) m_wid[b] = data[15:8];
      end
      default: if (strb[0]) begin
        if (data[0]) m_wwrap[b] = 0;
        if (data[1]) m_rwrap[b] = 0;
      end
    endcase
  endfunction

  function automatic void m_read(input logic [31:0] addr, output logic [31:0] data,
                                 output logic [1:0] resp, output bit known);
    int b, off, diff;
    data = 0; resp = 2'b10; known = 1;
    if ((addr / STRIDE) >= NUM_BUF) return;
    b   = int'(addr / STRIDE);
    off = int'(addr % STRIDE) & ~3;
    if (off > 'h10) return;
    resp = 2'b00;
    case (off)
      'h00: begin
        data  = m_mem[b][m_rd[b]];
        known = m_known[b][m_rd[b]];
        m_rd[b] = (m_rd[b] + 1) % DEPTH;
        if (m_rd[b] == 0) m_rwrap[b] = 1;
      end
      'h04: data = m_wr[b];
      'h08: data = m_rd[b];
      'h0C: data = m_wid[b] * 256 + m_len[b];
      default: begin
        diff = (m_wr[b] - m_rd[b] + DEPTH) % DEPTH;
        data = diff * 65536 + m_rwrap[b] * 2 + m_wwrap[b];
      end
    endcase
  endfunction

  // ---------------- bus drivers ----------------
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    @(negedge clk);
    axil.s_awvalid = 1'b1; axil.s_awaddr = addr;
    n = 0;
    while (!axil.s_awready && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) begin axil.s_awvalid = 1'b0; expire("awready"); return; end
    @(negedge clk);
    axil.s_awvalid = 1'b0;
    axil.s_wvalid = 1'b1; axil.s_wdata = data; axil.s_wstrb = strb;
    n = 0;
    while (!axil.s_wready && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) begin axil.s_wvalid = 1'b0; expire("wready"); return; end
    @(negedge clk);
    axil.s_wvalid = 1'b0;
    n = 0;
    while (!axil.s_bvalid && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) begin expire("bvalid"); return; end
    resp = axil.s_bresp;
  endtask

  task automatic bus_read(input logic [31:0] addr, input int hold, input logic [31:0] hold_exp,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    data = 'x; resp = 2'bxx;
    @(negedge clk);
    axil.s_arvalid = 1'b1; axil.s_araddr = addr;
    axil.s_rready = (hold == 0);
    n = 0;
    while (!axil.s_arready && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) begin axil.s_arvalid = 1'b0; axil.s_rready = 1'b1; expire("arready"); return; end
    @(negedge clk);
    axil.s_arvalid = 1'b0;
    n = 0;
    while (!axil.s_rvalid && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) begin axil.s_rready = 1'b1; expire("rvalid"); return; end
    data = axil.s_rdata;
    resp = axil.s_rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rvalid", 32'(axil.s_rvalid), 32'h1);
      check("hold_rdata", axil.s_rdata, hold_exp);
    end
    axil.s_rready = 1'b1;
  endtask

  task automatic do_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic [1:0] exp_resp);
    logic [1:0] resp, mresp;
    bus_write(addr, data, strb, resp);
    m_write(addr, data, strb, mresp);
    check($sformatf("bresp@%h", addr), 32'(resp), 32'(exp_resp));
  endtask

  task automatic do_r(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] data, mdata;
    logic [1:0] resp, mresp;
    bit known;
    bus_read(addr, 0, 32'h0, data, resp);
    m_read(addr, mdata, mresp, known);
    check($sformatf("rdata@%h", addr), data, exp_data);
    check($sformatf("rresp@%h", addr), 32'(resp), 32'(exp_resp));
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [31:0] exp_data,
                              input logic [1:0] exp_resp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
    v.exp_data = exp_data; v.exp_resp = exp_resp;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] d, a, mdata, rdata;
    logic [1:0]  resp, mresp;
    logic [3:0]  s;
    bit known, seen_bvalid;
    int b, o, p;

    axil.s_awvalid = 0; axil.s_awaddr = 0; axil.s_wvalid = 0; axil.s_wdata = 0; axil.s_wstrb = 0;
    axil.s_bready = 1; axil.s_arvalid = 0; axil.s_araddr = 0; axil.s_rready = 1;
    core_rd_en = 0; core_rd_buf = 0; core_rd_addr = 0;
    m_reset();
    for (int i = 0; i < NUM_BUF; i++) for (int j = 0; j < DEPTH; j++) m_known[i][j] = 0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_awready", 32'(axil.s_awready), 32'h1);
    check("rst_arready", 32'(axil.s_arready), 32'h1);
    check("rst_wready", 32'(axil.s_wready), 32'h0);
    check("rst_bvalid", 32'(axil.s_bvalid), 32'h0);
    check("rst_rvalid", 32'(axil.s_rvalid), 32'h0);
    check("rst_rdata", axil.s_rdata, 32'h0);
    check("rst_resp", 32'({axil.s_bresp, axil.s_rresp}), 32'h0);
    check("rst_core", core_rd_data, 32'h0);
    check("rst_cfg", {cfg_width, cfg_length}, 32'h0);

    add(1, 32'h00, 32'hA5A5_0001, 4'hF, 0, 2'b00);
    add(1, 32'h00, 32'hA5A5_0002, 4'hF, 0, 2'b00);
    add(1, 32'h00, 32'hA5A5_0003, 4'hF, 0, 2'b00);
    add(1, 32'h00, 32'hA5A5_0004, 4'hF, 0, 2'b00);
    add(0, 32'h04, 0, 0, 32'h4, 2'b00);
    add(1, 32'h08, 32'h0, 4'hF, 0, 2'b00);
    add(0, 32'h00, 0, 0, 32'hA5A5_0001, 2'b00);
    add(0, 32'h00, 0, 0, 32'hA5A5_0002, 2'b00);
    add(0, 32'h00, 0, 0, 32'hA5A5_0003, 2'b00);
    add(0, 32'h00, 0, 0, 32'hA5A5_0004, 2'b00);
    add(0, 32'h08, 0, 0, 32'h4, 2'b00);
    add(0, 32'h10, 0, 0, 32'h0, 2'b00);
    add(1, 32'h2C, 32'h0000_0C08, 4'hF, 0, 2'b00);
    add(0, 32'h2C, 0, 0, 32'h0000_0C08, 2'b00);
    add(0, 32'h0C, 0, 0, 32'h0, 2'b00);
    add(0, 32'h14, 0, 0, 32'h0, 2'b10);
    add(0, 32'h40, 0, 0, 32'h0, 2'b10);
    add(1, 32'h40, 32'hFFFF_FFFF, 4'hF, 0, 2'b10);
    add(1, 32'h14, 32'hFFFF_FFFF, 4'hF, 0, 2'b10);
    add(1, 32'h04, 32'h9, 4'b1110, 0, 2'b00);
    add(0, 32'h04, 0, 0, 32'h4, 2'b00);
    add(1, 32'h24, 32'h5, 4'hF, 0, 2'b00);
    add(0, 32'h30, 0, 0, 32'h0005_0000, 2'b00);
    add(1, 32'h2C, 32'hFFFF_FF55, 4'b0001, 0, 2'b00);
    add(0, 32'h2F, 0, 0, 32'h0000_0C55, 2'b00);

    foreach (vecs[i]) begin
      if (vecs[i].wr) do_w(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
      else do_r(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
    end
    check("cfg_length", 32'(cfg_length), 32'h5500);
    check("cfg_width", 32'(cfg_width), 32'h0C00);

    // pointer wrap and sticky status
    do_w(32'h04, 32'hFF, 4'hF, 2'b00);
    do_w(32'h00, 32'h1234, 4'hF, 2'b00);
    do_r(32'h04, 32'h0, 2'b00);
    do_r(32'h10, 32'h00FC_0001, 2'b00);
    do_w(32'h10, 32'h1, 4'hF, 2'b00);
    do_r(32'h10, 32'h00FC_0000, 2'b00);
    do_w(32'h08, 32'hFF, 4'hF, 2'b00);
    do_r(32'h00, 32'h0000_1234, 2'b00);
    do_r(32'h08, 32'h0, 2'b00);
    do_r(32'h10, 32'h0000_0002, 2'b00);
    do_w(32'h10, 32'h2, 4'hF, 2'b00);
    do_r(32'h10, 32'h0, 2'b00);

    // byte-enabled DATA write seen through the core port
    do_w(32'h04, 32'h10, 4'hF, 2'b00);
    do_w(32'h00, 32'h1111_1111, 4'hF, 2'b00);
    do_w(32'h04, 32'h10, 4'hF, 2'b00);
    do_w(32'h00, 32'hFFFF_FFFF, 4'b0010, 2'b00);
    @(negedge clk);
    core_rd_en = 1; core_rd_buf = 0; core_rd_addr = 8'h10;
    @(negedge clk);
    core_rd_en = 0;
    check("core_strb", core_rd_data, 32'h1111_FF11);
    do_w(32'h08, 32'h10, 4'hF, 2'b00);
    do_r(32'h00, 32'h1111_FF11, 2'b00);

    // response held while rready is low
    do_w(32'h08, 32'h0, 4'hF, 2'b00);
    bus_read(32'h00, 10, 32'hA5A5_0001, rdata, resp);
    m_read(32'h00, mdata, mresp, known);
    check("hold_first", rdata, 32'hA5A5_0001);
    check("hold_resp", 32'(resp), 32'h0);

    // reset asserted after the address phase of a write
    @(negedge clk);
    axil.s_awvalid = 1; axil.s_awaddr = 32'h0;
    @(negedge clk);
    axil.s_awvalid = 0; axil.s_wvalid = 1; axil.s_wdata = 32'hDEAD_BEEF; axil.s_wstrb = 4'hF;
    #2 rst_n = 1'b0;
    #1 check("abort_wready", 32'(axil.s_wready), 32'h0);
    @(negedge clk);
    axil.s_wvalid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    seen_bvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axil.s_bvalid) seen_bvalid = 1;
    end
    check("abort_no_bvalid", 32'(seen_bvalid), 32'h0);
    check("abort_awready", 32'(axil.s_awready), 32'h1);
    check("abort_cfg", 32'(cfg_width), 32'h0);
    do_r(32'h04, 32'h0, 2'b00);
    do_r(32'h00, 32'hA5A5_0001, 2'b00);

    // randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      b = $urandom_range(0, NUM_BUF);
      o = 4 * $urandom_range(0, 6);
      a = 32'(b * STRIDE + o + $urandom_range(0, 3));
      d = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if (o == 4 || o == 8) d = $urandom_range(0, 1) ? $urandom_range(250, 255) : $urandom_range(0, 8);
      if (o == 'h10) d = $urandom_range(0, 3);
      if ($urandom_range(0, 1)) begin
        bus_write(a, d, s, resp);
        m_write(a, d, s, mresp);
        check($sformatf("rnd_bresp@%h", a), 32'(resp), 32'(mresp));
      end else begin
        bus_read(a, 0, 32'h0, rdata, resp);
        m_read(a, mdata, mresp, known);
        check($sformatf("rnd_rresp@%h", a), 32'(resp), 32'(mresp));
        if (known) check($sformatf("rnd_rdata@%h", a), rdata, mdata);
      end
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, NUM_BUF - 1);
        p = (m_wr[b] + DEPTH - 1 - $urandom_range(0, 2)) % DEPTH;
        @(negedge clk);
        core_rd_en = 1; core_rd_buf = 1'(b); core_rd_addr = 8'(p);
        @(negedge clk);
        core_rd_en = 0;
        if (m_known[b][p]) check("rnd_core", core_rd_data, m_mem[b][p]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

endmodule
